read_dq_eye_trainer: RTL and testbench

READ_DQ_EYE_TRAINER -- requirements
Module: read_dq_eye_trainer

---
 rtl/read_train_pkg.sv | 28 ++
 rtl/read_eye_sample_chk.sv | 47 ++++
 rtl/read_dq_eye_trainer.sv | 197 +++++++++++++++++++
 tb/tb_read_dq_eye_trainer.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/read_train_pkg.sv
// Shared state encoding, default parameters and helpers for the read DQ eye trainer.
package read_train_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        SETTLE,
        SAMPLE,
        STEP,
        CENTER,
        DONE_S,
        FAIL_S
    } train_state_t;

    localparam int         DEF_TAP_MAX     = 255;
    localparam int         DEF_SETTLE_CYC  = 8;
    localparam int         DEF_SAMPLE_CYC  = 16;
    localparam int         DEF_MIN_WIDTH   = 4;
    localparam logic [7:0] DEF_EXP_PATTERN = 8'b01010101;

    // Midpoint of the eye, using a 9-bit sum so wide windows near the top tap cannot wrap.
    function automatic logic [7:0] eye_mid(input logic [7:0] left, input logic [7:0] right);
        logic [8:0] sum;
        sum = {1'b0, left} + {1'b0, right};
        return sum[8:1];
    endfunction

endpackage

// File: rtl/read_eye_sample_chk.sv
// Per-tap sample window: counts SAMPLE_CYC words and accumulates pattern and eye-flag errors.
module read_eye_sample_chk
    import read_train_pkg::*;
#(
    parameter int         SAMPLE_CYC  = DEF_SAMPLE_CYC,
    parameter logic [7:0] EXP_PATTERN = DEF_EXP_PATTERN
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic [7:0] rx_data,
    input  logic       early,
    input  logic       late,
    output logic       sample_done,
    output logic       sample_pass
);

    localparam logic [15:0] LAST = 16'(SAMPLE_CYC - 1);

    logic [15:0] cnt_q, cnt_d;
    logic        ok_q, ok_d;
    logic        word_ok;

    // The final word is folded in combinationally so the verdict is ready in the last sample cycle.
    always_comb begin
        word_ok     = (rx_data == EXP_PATTERN) && !early && !late;
        sample_done = en && (cnt_q == LAST);
        sample_pass = ok_q && word_ok;
        cnt_d       = '0;
        ok_d        = 1'b1;
        if (en && !sample_done) begin
            cnt_d = cnt_q + 16'd1;
            ok_d  = ok_q && word_ok;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
            ok_q  <= 1'b1;
        end else begin
            cnt_q <= cnt_d;
            ok_q  <= ok_d;
        end
    end

endmodule

// File: rtl/read_dq_eye_trainer.sv
// Sweeps the read DQ delay line upward, finds the first passing window and parks the tap at its centre.
module read_dq_eye_trainer
    import read_train_pkg::*;
#(
    parameter int         TAP_MAX     = DEF_TAP_MAX,
    parameter int         SETTLE_CYC  = DEF_SETTLE_CYC,
    parameter int         SAMPLE_CYC  = DEF_SAMPLE_CYC,
    parameter int         MIN_WIDTH   = DEF_MIN_WIDTH,
    parameter logic [7:0] EXP_PATTERN = DEF_EXP_PATTERN
) (
    input  logic       FAB_CLK,
    input  logic       RX_SYNC_RST,
    input  logic       START,
    input  logic [7:0] RX_DATA,
    input  logic       EYE_MONITOR_EARLY,
    input  logic       EYE_MONITOR_LATE,
    input  logic       DELAY_LINE_OUT_OF_RANGE,
    output logic       DELAY_LINE_MOVE,
    output logic       DELAY_LINE_DIRECTION,
    output logic       DELAY_LINE_LOAD,
    output logic       EYE_MONITOR_CLEAR_FLAGS,
    output logic       BUSY,
    output logic       DONE,
    output logic       FAIL,
    output logic [7:0] TAP_CNT,
    output logic [7:0] EYE_LEFT,
    output logic [7:0] EYE_RIGHT,
    output logic [7:0] EYE_CENTER
);

    localparam logic [15:0] SETTLE_LAST = 16'(SETTLE_CYC - 1);
    localparam logic [7:0]  TAP_LAST    = 8'(TAP_MAX);
    localparam logic [8:0]  MIN_W       = 9'(MIN_WIDTH);

    train_state_t state_q, state_d;
    logic [15:0]  settle_cnt_q, settle_cnt_d;
    logic [7:0]   tap_q, tap_d, left_q, left_d, right_q, right_d, center_q, center_d;
    logic         have_pass_q, have_pass_d, phase_q, phase_d;
    logic         move_q, move_d, dir_q, dir_d, load_q, load_d, clear_q, clear_d;
    logic         busy_q, busy_d, done_q, done_d, fail_q, fail_d;
    logic         tap_end, tap_pass, center_move;
    logic [8:0]   width;
    logic         sample_done, sample_pass;

    read_eye_sample_chk #(
        .SAMPLE_CYC (SAMPLE_CYC),
        .EXP_PATTERN(EXP_PATTERN)
    ) u_sample_chk (
        .clk        (FAB_CLK),
        .rst        (RX_SYNC_RST),
        .en         (state_q == SAMPLE),
        .rx_data    (RX_DATA),
        .early      (EYE_MONITOR_EARLY),
        .late       (EYE_MONITOR_LATE),
        .sample_done(sample_done),
        .sample_pass(sample_pass)
    );

    always_comb begin
        state_d      = state_q;
        settle_cnt_d = '0;
        tap_d        = tap_q;
        left_d       = left_q;
        right_d      = right_q;
        center_d     = center_q;
        have_pass_d  = have_pass_q;
        phase_d      = 1'b0;
        dir_d        = dir_q;
        tap_end      = 1'b0;
        tap_pass     = 1'b0;
        center_move  = 1'b0;
        width        = '0;

        case (state_q)
            IDLE, DONE_S, FAIL_S: begin
                if (START) begin
                    state_d     = LOAD;
                    left_d      = '0;
                    right_d     = '0;
                    center_d    = '0;
                    have_pass_d = 1'b0;
                end
            end
            LOAD: begin
                tap_d   = '0;
                state_d = SETTLE;
            end
            SETTLE: begin
                if (DELAY_LINE_OUT_OF_RANGE) tap_end = 1'b1;
                else if (settle_cnt_q == SETTLE_LAST) state_d = SAMPLE;
                else settle_cnt_d = settle_cnt_q + 16'd1;
            end
            SAMPLE: begin
                if (DELAY_LINE_OUT_OF_RANGE) tap_end = 1'b1;
                else if (sample_done) begin
                    tap_end  = 1'b1;
                    tap_pass = sample_pass;
                end
            end
            STEP: begin
                tap_d   = tap_q + 8'd1;
                state_d = SETTLE;
            end
            CENTER: begin
                // Alternate pulse/gap cycles so each MOVE is isolated.
                if (phase_q) phase_d = 1'b0;
                else if (tap_q == center_q) state_d = DONE_S;
                else begin
                    center_move = 1'b1;
                    tap_d       = tap_q - 8'd1;
                    phase_d     = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        if (tap_end) begin
            if (tap_pass) begin
                if (!have_pass_q) begin
                    left_d      = tap_q;
                    have_pass_d = 1'b1;
                end
                right_d = tap_q;
            end
            if ((!tap_pass && have_pass_q) || (tap_q == TAP_LAST) || DELAY_LINE_OUT_OF_RANGE) begin
                width = {1'b0, right_d} - {1'b0, left_d} + 9'd1;
                if (!have_pass_d || (width < MIN_W)) state_d = FAIL_S;
                else begin
                    center_d = eye_mid(left_d, right_d);
                    state_d  = CENTER;
                end
            end else begin
                state_d = STEP;
            end
        end

        if (state_d == STEP) dir_d = 1'b1;
        else if (state_d == CENTER && state_q != CENTER) dir_d = 1'b0;

        move_d  = center_move || (state_d == STEP);
        load_d  = (state_d == LOAD);
        clear_d = (state_d == SETTLE) && (state_q != SETTLE);
        busy_d  = (state_d == LOAD) || (state_d == SETTLE) || (state_d == SAMPLE) ||
                  (state_d == STEP) || (state_d == CENTER);
        done_d  = (state_d == DONE_S);
        fail_d  = (state_d == FAIL_S);
    end

    always_ff @(posedge FAB_CLK) begin
        if (RX_SYNC_RST) begin
            state_q      <= IDLE;
            settle_cnt_q <= '0;
            tap_q        <= '0;
            left_q       <= '0;
            right_q      <= '0;
            center_q     <= '0;
            have_pass_q  <= 1'b0;
            phase_q      <= 1'b0;
            move_q       <= 1'b0;
            dir_q        <= 1'b0;
            load_q       <= 1'b0;
            clear_q      <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            fail_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            settle_cnt_q <= settle_cnt_d;
            tap_q        <= tap_d;
            left_q       <= left_d;
            right_q      <= right_d;
            center_q     <= center_d;
            have_pass_q  <= have_pass_d;
            phase_q      <= phase_d;
            move_q       <= move_d;
            dir_q        <= dir_d;
            load_q       <= load_d;
            clear_q      <= clear_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            fail_q       <= fail_d;
        end
    end

    assign DELAY_LINE_MOVE         = move_q;
    assign DELAY_LINE_DIRECTION    = dir_q;
    assign DELAY_LINE_LOAD         = load_q;
    assign EYE_MONITOR_CLEAR_FLAGS = clear_q;
    assign BUSY                    = busy_q;
    assign DONE                    = done_q;
    assign FAIL                    = fail_q;
    assign TAP_CNT                 = tap_q;
    assign EYE_LEFT                = left_q;
    assign EYE_RIGHT               = right_q;
    assign EYE_CENTER              = center_q;

endmodule

// File: tb/tb_read_dq_eye_trainer.sv
// Directed bench: a delay-line/data-eye model driven by the DUT's MOVE/LOAD outputs.
module tb_read_dq_eye_trainer;

    logic       FAB_CLK = 1'b0;
    logic       RX_SYNC_RST = 1'b1;
    logic       START = 1'b0;
    logic [7:0] RX_DATA = '0;
    logic       EYE_MONITOR_EARLY = 1'b0;
    logic       EYE_MONITOR_LATE = 1'b0;
    logic       DELAY_LINE_OUT_OF_RANGE = 1'b0;
    logic       DELAY_LINE_MOVE, DELAY_LINE_DIRECTION, DELAY_LINE_LOAD, EYE_MONITOR_CLEAR_FLAGS;
    logic       BUSY, DONE, FAIL;
    logic [7:0] TAP_CNT, EYE_LEFT, EYE_RIGHT, EYE_CENTER;

    always #5 FAB_CLK = ~FAB_CLK;

    read_dq_eye_trainer #(
        .TAP_MAX    (255),
        .SETTLE_CYC (8),
        .SAMPLE_CYC (16),
        .MIN_WIDTH  (4),
        .EXP_PATTERN(8'b01010101)
    ) dut (
        .FAB_CLK                (FAB_CLK),
        .RX_SYNC_RST            (RX_SYNC_RST),
        .START                  (START),
        .RX_DATA                (RX_DATA),
        .EYE_MONITOR_EARLY      (EYE_MONITOR_EARLY),
        .EYE_MONITOR_LATE       (EYE_MONITOR_LATE),
        .DELAY_LINE_OUT_OF_RANGE(DELAY_LINE_OUT_OF_RANGE),
        .DELAY_LINE_MOVE        (DELAY_LINE_MOVE),
        .DELAY_LINE_DIRECTION   (DELAY_LINE_DIRECTION),
        .DELAY_LINE_LOAD        (DELAY_LINE_LOAD),
        .EYE_MONITOR_CLEAR_FLAGS(EYE_MONITOR_CLEAR_FLAGS),
        .BUSY                   (BUSY),
        .DONE                   (DONE),
        .FAIL                   (FAIL),
        .TAP_CNT                (TAP_CNT),
        .EYE_LEFT               (EYE_LEFT),
        .EYE_RIGHT              (EYE_RIGHT),
        .EYE_CENTER             (EYE_CENTER)
    );

    int checks = 0;
    int errors = 0;

    int win_lo = 1, win_hi = 0, late_tap = -1, oor_tap = 1000;
    bit early_all = 1'b0;
    int tap_model = 0, at_tap_cyc = 0;
    int inc_moves = 0, dec_moves = 0, loads = 0, bad_overlap = 0, bad_spacing = 0;
    logic prev_move = 1'b0;

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Delay line and data-eye model; reacts to registered DUT controls on the falling edge.
    always @(negedge FAB_CLK) begin
        if (DELAY_LINE_LOAD && DELAY_LINE_MOVE) bad_overlap++;
        if (prev_move && DELAY_LINE_MOVE) bad_spacing++;
        prev_move = DELAY_LINE_MOVE;
        if (DELAY_LINE_LOAD) begin
            loads++;
            tap_model  = 0;
            at_tap_cyc = 0;
        end else if (DELAY_LINE_MOVE) begin
            if (DELAY_LINE_DIRECTION) begin
                inc_moves++;
                tap_model++;
            end else begin
                dec_moves++;
                tap_model--;
            end
            at_tap_cyc = 0;
        end else begin
            at_tap_cyc++;
        end
        RX_DATA                 = (tap_model >= win_lo && tap_model <= win_hi) ? 8'h55 : 8'hAA;
        EYE_MONITOR_EARLY       = early_all;
        EYE_MONITOR_LATE        = (tap_model == late_tap) && (at_tap_cyc == 15);
        DELAY_LINE_OUT_OF_RANGE = (tap_model >= oor_tap);
    end

    task automatic setup(input int lo, input int hi, input int late, input int oor, input bit early);
        win_lo = lo; win_hi = hi; late_tap = late; oor_tap = oor; early_all = early;
        inc_moves = 0; dec_moves = 0; loads = 0; bad_overlap = 0; bad_spacing = 0;
    endtask

    task automatic pulse_start();
        @(negedge FAB_CLK) START = 1'b1;
        @(negedge FAB_CLK) START = 1'b0;
    endtask

    // Runs one training with a stray START mid-sweep, which must be ignored.
    task automatic run_train(input string tag);
        int cyc;
        pulse_start();
        cyc = 0;
        while (!(DONE || FAIL) && cyc < 20000) begin
            @(negedge FAB_CLK);
            START = (cyc == 500);
            cyc++;
        end
        START = 1'b0;
        check({tag, "_finished"}, int'(DONE || FAIL), 1);
        check({tag, "_loads"}, loads, 1);
        check({tag, "_overlap"}, bad_overlap, 0);
        check({tag, "_spacing"}, bad_spacing, 0);
        check({tag, "_busy"}, int'(BUSY), 0);
    endtask

    initial begin
        repeat (3) @(negedge FAB_CLK);
        check("rst_busy", int'(BUSY), 0);
        check("rst_done", int'(DONE), 0);
        check("rst_fail", int'(FAIL), 0);
        check("rst_tap", int'(TAP_CNT), 0);
        check("rst_move_load", int'({DELAY_LINE_MOVE, DELAY_LINE_LOAD}), 0);
        @(negedge FAB_CLK) RX_SYNC_RST = 1'b0;

        // Window 20..60
        setup(20, 60, -1, 1000, 1'b0);
        run_train("win");
        check("win_done", int'(DONE), 1);
        check("win_fail", int'(FAIL), 0);
        check("win_left", int'(EYE_LEFT), 20);
        check("win_right", int'(EYE_RIGHT), 60);
        check("win_center", int'(EYE_CENTER), 40);
        check("win_tap", int'(TAP_CNT), 40);
        check("win_model_tap", tap_model, 40);
        check("win_inc", inc_moves, 61);
        check("win_dec", dec_moves, 21);

        // Never passes: data good but EARLY always set
        setup(0, 255, -1, 1000, 1'b1);
        run_train("none");
        check("none_fail", int'(FAIL), 1);
        check("none_done", int'(DONE), 0);
        check("none_tap", int'(TAP_CNT), 255);
        check("none_inc", inc_moves, 255);
        check("none_dec", dec_moves, 0);

        // Narrow window 100..102
        setup(100, 102, -1, 1000, 1'b0);
        run_train("narrow");
        check("narrow_fail", int'(FAIL), 1);
        check("narrow_done", int'(DONE), 0);
        check("narrow_left", int'(EYE_LEFT), 100);
        check("narrow_right", int'(EYE_RIGHT), 102);

        // Out of range at tap 90
        setup(50, 255, -1, 90, 1'b0);
        run_train("oor");
        check("oor_done", int'(DONE), 1);
        check("oor_left", int'(EYE_LEFT), 50);
        check("oor_right", int'(EYE_RIGHT), 89);
        check("oor_center", int'(EYE_CENTER), 69);
        check("oor_tap", int'(TAP_CNT), 69);
        check("oor_dec", dec_moves, 21);

        // Single LATE pulse at tap 45
        setup(20, 60, 45, 1000, 1'b0);
        run_train("late");
        check("late_done", int'(DONE), 1);
        check("late_left", int'(EYE_LEFT), 20);
        check("late_right", int'(EYE_RIGHT), 44);
        check("late_center", int'(EYE_CENTER), 32);
        check("late_tap", int'(TAP_CNT), 32);

        // Reset with START while sampling tap 30
        setup(20, 60, -1, 1000, 1'b0);
        pulse_start();
        for (int i = 0; i < 5000 && !(tap_model == 30 && at_tap_cyc == 14); i++) @(negedge FAB_CLK);
        check("mid_reached_tap30", tap_model, 30);
        RX_SYNC_RST = 1'b1;
        START = 1'b1;
        @(negedge FAB_CLK);
        RX_SYNC_RST = 1'b0;
        START = 1'b0;
        check("mid_rst_busy", int'(BUSY), 0);
        check("mid_rst_flags", int'({DONE, FAIL, DELAY_LINE_MOVE, DELAY_LINE_DIRECTION, DELAY_LINE_LOAD, EYE_MONITOR_CLEAR_FLAGS}), 0);
        check("mid_rst_tap", int'(TAP_CNT), 0);
        check("mid_rst_eye", int'({EYE_LEFT, EYE_RIGHT, EYE_CENTER}), 0);
        setup(20, 60, -1, 1000, 1'b0);
        repeat (20) @(negedge FAB_CLK);
        check("idle_untouched", inc_moves + dec_moves + loads, 0);
        @(negedge FAB_CLK) START = 1'b1;
        @(negedge FAB_CLK) START = 1'b0;
        check("restart_load_hi", int'(DELAY_LINE_LOAD), 1);
        @(negedge FAB_CLK);
        check("restart_load_lo", int'(DELAY_LINE_LOAD), 0);
        for (int i = 0; i < 20000 && !(DONE || FAIL); i++) @(negedge FAB_CLK);
        check("restart_done", int'(DONE), 1);
        check("restart_center", int'(EYE_CENTER), 40);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
